instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage for the 16-bit core: owns the PC and issues one read per cycle to a synchronous instruction memory.
//  Delivers registered {if_instr, if_pc, if_valid} to the IF/ID boundary.
//  Takes control-flow redirects (nxt_pc for taken B, CALL, RET) from the EX-stage jump unit.
//  Absorbs decode stalls through a one-entry skid buffer, so no fetch is lost or duplicated.
// PARAMETERS
//  RESET_PC  16'h0000  PC fetched first after reset
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   reset, synchronous, active-high
//  stall        in   1   IF/ID hold request from hazard/decode logic
//  redirect     in   1   EX redirect strobe (control-flow change resolved)
//  redirect_pc  in   16  new fetch address (jump unit nxt_pc)
//  imem_rd      out  1   instruction memory read enable
//  imem_addr    out  16  instruction memory word address
//  imem_data    in   16  read data, valid the cycle after imem_rd=1
//  if_instr     out  16  instruction to decode (16'h0000 when invalid)
//  if_pc        out  16  word address of if_instr; EX uses it as pc
//  if_valid     out  1   if_instr/if_pc hold a live instruction
// BEHAVIOUR
//  State
//  - fetch_pc[15:0]: next address to read.
//  - pend, pend_pc: a read was issued last cycle; its data is on imem_data this cycle.
//  - skid_v, skid_instr, skid_pc: one-entry skid buffer.
//  - Invariant: skid_v=1 implies pend=0.
//  Per-cycle priority: rst > redirect > stall > run.
//  - rst:
//    - fetch_pc<=RESET_PC; pend, skid_v, if_valid <= 0; if_instr, if_pc <= 0.
//    - imem_rd=0 while rst=1. Also discards any skid or pending data mid-operation.
//  - redirect (stall ignored):
//    - Combinational: imem_rd=1, imem_addr=redirect_pc.
//    - Next state: fetch_pc<=redirect_pc+1; pend<=1, pend_pc<=redirect_pc; skid_v<=0.
//    - Flush: if_valid<=0, if_instr<=0. In-flight imem_data is dropped.
//  - stall, no redirect:
//    - imem_rd=0. fetch_pc and all if_* outputs hold.
//    - If pend: skid_instr<=imem_data, skid_pc<=pend_pc, skid_v<=1, pend<=0.
//  - run (no stall, no redirect):
//    - Issue: imem_rd=1, imem_addr=fetch_pc; fetch_pc<=fetch_pc+1; pend<=1, pend_pc<=fetch_pc.
//    - Output load: from skid if skid_v (skid_v<=0); else from imem_data/pend_pc if pend; else if_valid<=0, if_instr<=0.
//  - imem_addr = fetch_pc whenever imem_rd=0 and no redirect (don't-care to memory).
//  Timing / latency
//  - Throughput: 1 instr/cycle when unstalled.
//  - Read issued in cycle N appears on if_* from cycle N+2.
//  - First cycle with rst=0 is cycle 0: fetches RESET_PC; if_valid=1 from cycle 2.
//  - Redirect in cycle N: if_valid=0 in N+1; redirect_pc instr valid in N+2.
//  Arithmetic and corner cases
//  - PC arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000.
//  - Stall release: skid entry is presented first; the new read issued the same cycle follows next cycle, with no bubble or duplicate.
//  - Stall of any length: at most one entry captured; later stall cycles change nothing.
// TESTING  (imem model: mem[a] = a ^ 16'hA5A5, 1-cycle read latency)
//  1 Reset release, no stall -> if_valid first 1 in cycle 2; if_pc 0000,0001,0002,... each cycle; if_instr = if_pc^A5A5.
//  2 stall high 3 cycles while if_pc=0005 -> if_pc/instr hold 0005, imem_rd=0; after release if_pc 0006,0007 with no gap or repeat.
//  3 redirect=1, redirect_pc=C000 while if_pc=0010 -> same cycle imem_addr=C000; next cycle if_valid=0, if_instr=0000; then if_pc C000, C001.
//  4 redirect=1 and stall=1 same cycle with skid full -> skid flushed; stream resumes at redirect_pc as in test 3.
//  5 redirect_pc=FFFF -> if_pc FFFF then 0000 (wrap).
//  6 rst pulse during stall with skid full -> all outputs 0 next cycle; restart at RESET_PC, valid 2 cycles after rst drops.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage of the 16-bit core.
// PC owner, sync imem issue, skid buffer, IF/ID regs.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid
);

  logic [15:0] r_fetch_pc;
  logic        r_pend;
  logic [15:0] r_pend_pc;
  logic        r_skid_v;
  logic [15:0] r_skid_instr;
  logic [15:0] r_skid_pc;
  logic [15:0] r_if_instr;
  logic [15:0] r_if_pc;
  logic        r_if_valid;

  logic        w_rd;
  logic [15:0] w_addr;

  // Read issue: redirect wins over stall, reset blocks all reads.
  always_comb begin
    w_rd   = 1'b0;
    w_addr = r_fetch_pc;
    if (!rst) begin
      if (redirect) begin
        w_rd   = 1'b1;
        w_addr = redirect_pc;
      end else if (!stall) begin
        w_rd   = 1'b1;
      end
    end
  end

  // PC, pending read, skid entry and IF/ID register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_pend       <= 1'b0;
      r_pend_pc    <= 16'h0000;
      r_skid_v     <= 1'b0;
      r_skid_instr <= 16'h0000;
      r_skid_pc    <= 16'h0000;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 16'h0000;
      r_if_pc      <= 16'h0000;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc + 16'd1;
      r_pend     <= 1'b1;
      r_pend_pc  <= redirect_pc;
      r_skid_v   <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= 16'h0000;
    end else if (stall) begin
      if (r_pend) begin
        r_skid_instr <= imem_data;
        r_skid_pc    <= r_pend_pc;
        r_skid_v     <= 1'b1;
        r_pend       <= 1'b0;
      end
    end else begin
      r_fetch_pc <= r_fetch_pc + 16'd1;
      r_pend     <= 1'b1;
      r_pend_pc  <= r_fetch_pc;
      if (r_skid_v) begin
        r_skid_v   <= 1'b0;
        r_if_valid <= 1'b1;
        r_if_instr <= r_skid_instr;
        r_if_pc    <= r_skid_pc;
      end else if (r_pend) begin
        r_if_valid <= 1'b1;
        r_if_instr <= imem_data;
        r_if_pc    <= r_pend_pc;
      end else begin
        r_if_valid <= 1'b0;
        r_if_instr <= 16'h0000;
      end
    end
  end

  assign imem_rd   = w_rd;
  assign imem_addr = w_addr;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign if_valid  = r_if_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch.
// imem model: mem[a] = a ^ A5A5, one-cycle read latency.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;

  int n_tests;
  int n_fail;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_rd(imem_rd),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_valid(if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memory model
  always @(posedge clk)
    if (imem_rd) imem_data <= imem_addr ^ 16'hA5A5;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_tests++;
    if ({if_valid, if_pc, if_instr, imem_rd} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_out: v=%b pc=%h ins=%h rd=%b exp all 0",
               if_valid, if_pc, if_instr, imem_rd);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({imem_rd, imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_first_rd: rd=%b addr=%h exp 1 0000",
               imem_rd, imem_addr);
    end
    tick();
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle1: v=%b exp 0", if_valid);
    end
    tick();
  endtask

  task automatic test_stream;
    for (int k = 0; k < 6; k++) begin
      logic [15:0] p;
      p = 16'(k);
      n_tests++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, p, p ^ 16'hA5A5}) begin
        n_fail++;
        $display("FAIL stream_%0d: v=%b pc=%h ins=%h exp 1 %h %h",
                 k, if_valid, if_pc, if_instr, p, p ^ 16'hA5A5);
      end
      if (k < 5) tick();
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
    n_tests++;
    if ({imem_rd, imem_addr} !== {1'b0, 16'h0007}) begin
      n_fail++;
      $display("FAIL stall_rd: rd=%b addr=%h exp 0 0007",
               imem_rd, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({if_valid, if_pc, if_instr, imem_rd} !==
          {1'b1, 16'h0005, 16'hA5A0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: v=%b pc=%h ins=%h rd=%b exp 1 0005 a5a0 0",
                 i, if_valid, if_pc, if_instr, imem_rd);
      end
    end
    tick();
    stall = 1'b0;
    #1;
    n_tests++;
    if ({if_pc, imem_rd, imem_addr} !== {16'h0005, 1'b1, 16'h0007}) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h rd=%b addr=%h exp 0005 1 0007",
               if_pc, imem_rd, imem_addr);
    end
    for (int k = 6; k < 9; k++) begin
      logic [15:0] p;
      p = 16'(k);
      tick();
      n_tests++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, p, p ^ 16'hA5A5}) begin
        n_fail++;
        $display("FAIL stall_resume_%0d: v=%b pc=%h ins=%h exp 1 %h %h",
                 k, if_valid, if_pc, if_instr, p, p ^ 16'hA5A5);
      end
    end
  endtask

  task automatic test_redirect;
    repeat (8) tick();
    n_tests++;
    if (if_pc !== 16'h0010) begin
      n_fail++;
      $display("FAIL redir_pre: pc=%h exp 0010", if_pc);
    end
    redirect    = 1'b1;
    redirect_pc = 16'hC000;
    #1;
    n_tests++;
    if ({imem_rd, imem_addr} !== {1'b1, 16'hC000}) begin
      n_fail++;
      $display("FAIL redir_addr: rd=%b addr=%h exp 1 c000",
               imem_rd, imem_addr);
    end
    tick();
    redirect = 1'b0;
    n_tests++;
    if ({if_valid, if_instr} !== 17'h0) begin
      n_fail++;
      $display("FAIL redir_bubble: v=%b ins=%h exp 0 0000",
               if_valid, if_instr);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'hC000, 16'h65A5}) begin
      n_fail++;
      $display("FAIL redir_first: v=%b pc=%h ins=%h exp 1 c000 65a5",
               if_valid, if_pc, if_instr);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'hC001, 16'h65A4}) begin
      n_fail++;
      $display("FAIL redir_second: v=%b pc=%h ins=%h exp 1 c001 65a4",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_stall;
    stall = 1'b1;
    tick();
    n_tests++;
    if ({if_valid, if_pc} !== {1'b1, 16'hC001}) begin
      n_fail++;
      $display("FAIL rs_hold: v=%b pc=%h exp 1 c001", if_valid, if_pc);
    end
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    #1;
    n_tests++;
    if ({imem_rd, imem_addr} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL rs_addr: rd=%b addr=%h exp 1 1234",
               imem_rd, imem_addr);
    end
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    n_tests++;
    if ({if_valid, if_instr} !== 17'h0) begin
      n_fail++;
      $display("FAIL rs_bubble: v=%b ins=%h exp 0 0000",
               if_valid, if_instr);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h1234, 16'hB791}) begin
      n_fail++;
      $display("FAIL rs_first: v=%b pc=%h ins=%h exp 1 1234 b791",
               if_valid, if_pc, if_instr);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h1235, 16'hB790}) begin
      n_fail++;
      $display("FAIL rs_second: v=%b pc=%h ins=%h exp 1 1235 b790",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'hFFFF, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL wrap_ffff: v=%b pc=%h ins=%h exp 1 ffff 5a5a",
               if_valid, if_pc, if_instr);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0000, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL wrap_0000: v=%b pc=%h ins=%h exp 1 0000 a5a5",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_rst_mid;
    stall = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (imem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rd: rd=%b exp 0", imem_rd);
    end
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    n_tests++;
    if ({if_valid, if_pc, if_instr, imem_rd, imem_addr} !==
        {1'b0, 16'h0, 16'h0, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL rstmid_clear: v=%b pc=%h ins=%h rd=%b addr=%h exp 0 0 0 1 0",
               if_valid, if_pc, if_instr, imem_rd, imem_addr);
    end
    tick();
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_c1: v=%b exp 0", if_valid);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0000, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL rstmid_c2: v=%b pc=%h ins=%h exp 1 0000 a5a5",
               if_valid, if_pc, if_instr);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0001, 16'hA5A4}) begin
      n_fail++;
      $display("FAIL rstmid_c3: v=%b pc=%h ins=%h exp 1 0001 a5a4",
               if_valid, if_pc, if_instr);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_data   = 16'h0000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
